// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory port, branch redirect
// from execute and the instruction handshake toward decode.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect, redirect_pc,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect, redirect_pc,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests and a
// two-entry instruction buffer toward decode, with branch redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [1:0][31:0] fpc_q, fpc_d;
  logic [1:0][31:0] fins_q, fins_d;
  logic             rd_q, rd_d;
  logic [1:0]       count_q, count_d;
  logic [1:0]       inflight_q, inflight_d;
  logic [1:0]       discard_q, discard_d;

  logic [2:0]  credit;
  logic [31:0] target;
  logic        gnt_fire;
  logic        rsp;
  logic        push;
  logic        pop;
  logic        wr_ptr;

  // Buffered plus outstanding words never exceed the buffer depth.
  assign credit = {1'b0, count_q} + {1'b0, inflight_q};
  assign target = bus.redirect_pc & 32'hFFFF_FFFC;

  assign bus.imem_req    = !reset && !bus.redirect
                         && (credit < 3'd2);
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.instr_valid = (count_q != 2'd0) && !bus.redirect;
  assign bus.instr       = fins_q[rd_q];
  assign bus.instr_pc    = fpc_q[rd_q];

  assign gnt_fire = bus.imem_req && bus.imem_gnt;
  assign rsp      = bus.imem_rvalid && (inflight_q != 2'd0);
  assign pop      = bus.instr_valid && bus.instr_ready;
  assign push     = rsp && !bus.redirect
                  && (discard_q == 2'd0);
  assign wr_ptr   = rd_q ^ count_q[0];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    fpc_d      = fpc_q;
    fins_d     = fins_q;
    rd_d       = rd_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    if (bus.redirect) begin
      fetch_pc_d = target;
      resp_pc_d  = target;
      count_d    = 2'd0;
      rd_d       = 1'b0;
      inflight_d = inflight_q - {1'b0, rsp};
      discard_d  = inflight_q - {1'b0, rsp};
    end else begin
      if (gnt_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      inflight_d = inflight_q + {1'b0, gnt_fire}
                 - {1'b0, rsp};
      if (rsp && (discard_q != 2'd0)) begin
        discard_d = discard_q - 2'd1;
      end
      if (push) begin
        fpc_d[wr_ptr]  = resp_pc_q;
        fins_d[wr_ptr] = bus.imem_rdata;
        resp_pc_d      = resp_pc_q + 32'd4;
      end
      if (pop) begin
        rd_d = ~rd_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      fpc_q      <= '0;
      fins_q     <= '0;
      rd_q       <= 1'b0;
      count_q    <= 2'd0;
      inflight_q <= 2'd0;
      discard_q  <= 2'd0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      fpc_q      <= fpc_d;
      fins_q     <= fins_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with epoch-tagged
// requests, directed corner sequences and a randomized run.
module tb_fetch_unit;
  localparam logic [31:0] K = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] exp_addr;
    logic [31:0] exp_next;
  } vec_t;

  req_t        memq[$];
  ent_t        mfifo[$];
  ent_t        dlv[$];
  logic [31:0] m_fetch;
  int          epoch;
  int          cyc;
  int          first_valid;
  int          checks;
  int          errors;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive, check against the model, advance.
  task automatic tick(input bit g, input bit rdy, input bit redir,
                      input logic [31:0] rpc, input int lat);
    req_t e;
    req_t n;
    ent_t h;
    bit   rv, er, ev, fire;
    int   d;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.instr_ready = rdy;
    rv = (memq.size() > 0) && (memq[0].due <= cyc);
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rv ? (memq[0].addr ^ K) : 32'h0;
    bus.imem_gnt    = g;
    #2;
    er = !redir && ((mfifo.size() + memq.size()) < 2);
    ev = !redir && (mfifo.size() != 0);
    chk("imem_req", 32'(bus.imem_req), 32'(er));
    if (er) chk("imem_addr", bus.imem_addr, m_fetch);
    chk("instr_valid", 32'(bus.instr_valid), 32'(ev));
    if (ev) begin
      chk("instr_pc", bus.instr_pc, mfifo[0].pc);
      chk("instr", bus.instr, mfifo[0].data);
    end
    if (bus.instr_valid && first_valid < 0) first_valid = cyc;
    if (bus.instr_valid && rdy) begin
      h.pc   = bus.instr_pc;
      h.data = bus.instr;
      dlv.push_back(h);
    end
    fire = er && g;
    if (rv) e = memq.pop_front();
    if (redir) begin
      mfifo.delete();
      epoch++;
      m_fetch = rpc & 32'hFFFF_FFFC;
    end else begin
      if (ev && rdy) void'(mfifo.pop_front());
      if (rv && e.epoch == epoch) begin
        h.pc   = e.addr;
        h.data = e.addr ^ K;
        mfifo.push_back(h);
      end
      if (fire) begin
        d = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
        n.addr  = m_fetch;
        n.epoch = epoch;
        n.due   = cyc + 1 + d;
        memq.push_back(n);
        m_fetch = m_fetch + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once.
  task automatic hard_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_req", 32'(bus.imem_req), 32'h0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_valid", 32'(bus.instr_valid), 32'h0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_pc", bus.instr_pc, 32'h0);
    memq.delete();
    mfifo.delete();
    dlv.delete();
    m_fetch = 32'h0;
    epoch++;
    first_valid = -1;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.instr_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  vec_t vt[4];

  initial begin
    checks = 0;
    errors = 0;
    epoch = 0;
    cyc = 0;
    first_valid = -1;
    m_fetch = 32'h0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.instr_ready = 1'b0;

    vt[0] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
    vt[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000};
    vt[2] = '{32'h0000_0002, 32'h0000_0000, 32'h0000_0004};
    vt[3] = '{32'h8000_0001, 32'h8000_0000, 32'h8000_0004};

    @(posedge clk);
    #1;
    hard_reset();

    // Zero-wait memory
    for (int i = 0; i < 12; i++) tick(1, 1, 0, 0, 0);
    chk("zw_first_valid", 32'(first_valid), 32'd2);
    chk("zw_ndeliv", 32'(dlv.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < dlv.size()) begin
        chk("zw_pc", dlv[i].pc, 32'(4 * i));
        chk("zw_data", dlv[i].data, 32'(4 * i) ^ K);
      end
    end

    // Backpressure
    hard_reset();
    for (int i = 0; i < 6; i++) tick(1, 0, 0, 0, 0);
    chk("bp_req_low", 32'(bus.imem_req), 32'h0);
    chk("bp_head_valid", 32'(bus.instr_valid), 32'h1);
    chk("bp_head_pc", bus.instr_pc, 32'h0);
    for (int i = 0; i < 10; i++) tick(1, 1, 0, 0, 0);
    chk("bp_ndeliv", 32'(dlv.size() >= 3), 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (i < dlv.size()) chk("bp_pc", dlv[i].pc, 32'(4 * i));
    end

    // Grant stall at 0x8
    hard_reset();
    tick(1, 1, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("gs_req", 32'(bus.imem_req), 32'h1);
      chk("gs_addr", bus.imem_addr, 32'h8);
      tick(0, 1, 0, 0, 0);
    end
    tick(1, 1, 0, 0, 0);
    chk("gs_next_addr", bus.imem_addr, 32'hC);

    // Redirect with two responses in flight
    hard_reset();
    tick(1, 1, 0, 0, 3);
    tick(1, 1, 0, 0, 3);
    tick(0, 1, 1, 32'h103, 0);
    dlv.delete();
    for (int i = 0; i < 12; i++) tick(1, 1, 0, 0, 0);
    chk("rd2_deliv", 32'(dlv.size() > 0), 32'd1);
    if (dlv.size() > 0) begin
      chk("rd2_pc", dlv[0].pc, 32'h100);
      chk("rd2_data", dlv[0].data, 32'h100 ^ K);
    end

    // Redirect coincident with a response
    hard_reset();
    tick(1, 1, 0, 0, 2);
    tick(1, 1, 0, 0, 2);
    tick(0, 1, 0, 0, 0);
    chk("rc_rvalid_due", 32'(memq.size()), 32'd2);
    tick(0, 1, 1, 32'h200, 0);
    dlv.delete();
    for (int i = 0; i < 10; i++) tick(1, 1, 0, 0, 0);
    chk("rc_deliv", 32'(dlv.size() > 0), 32'd1);
    if (dlv.size() > 0) chk("rc_pc", dlv[0].pc, 32'h200);

    // Full FIFO, then reset mid-operation
    hard_reset();
    for (int i = 0; i < 5; i++) tick(1, 0, 0, 0, 0);
    chk("full_valid", 32'(bus.instr_valid), 32'h1);
    hard_reset();
    for (int i = 0; i < 6; i++) tick(1, 1, 0, 0, 0);
    chk("rr_deliv", 32'(dlv.size() > 0), 32'd1);
    if (dlv.size() > 0) chk("rr_pc", dlv[0].pc, 32'h0);

    // Redirect target table
    hard_reset();
    for (int r = 0; r < 4; r++) begin
      dlv.delete();
      tick(0, 1, 1, vt[r].rpc, 0);
      chk("tb_addr", bus.imem_addr, vt[r].exp_addr);
      tick(1, 1, 0, 0, 0);
      chk("tb_next", bus.imem_addr, vt[r].exp_next);
      for (int i = 0; i < 3; i++) tick(0, 1, 0, 0, 0);
      chk("tb_deliv", 32'(dlv.size()), 32'd1);
      if (dlv.size() > 0) begin
        chk("tb_dpc", dlv[0].pc, vt[r].exp_addr);
        chk("tb_ddata", dlv[0].data, vt[r].exp_addr ^ K);
      end
    end

    // Randomized traffic
    hard_reset();
    for (int i = 0; i < 800; i++) begin
      tick(($urandom % 10) < 7, ($urandom % 10) < 7,
           ($urandom % 20) == 0, $urandom, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
